// File: rtl/synth_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : synth_pkg                                                   |
// | Shared types and constants for the synth voice allocator: command     |
// | word layout, field widths, special note codes, waveform and FSM       |
// | state encodings.                                                      |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package synth_pkg;

    // Command word layout (low 16 bits of the bus write)
    localparam int c_cmd_w        = 16;
    localparam int c_cmd_on_bit   = 15;
    localparam int c_cmd_note_lsb = 8;
    localparam int c_cmd_vel_lsb  = 0;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 8;

    // An "on" with this note rotates the waveform; an "off" with this note
    // silences every voice.
    localparam logic [NOTE_W-1:0] WAVE_CMD_NOTE = 7'd0;
    localparam logic [NOTE_W-1:0] STOP_ALL_NOTE = 7'd127;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/synth_cmd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : synth_cmd_fifo                                              |
// | First-word-fall-through command FIFO. A push into a full FIFO is      |
// | accepted only when a pop happens in the same cycle.                   |
// | Ports   : clk, reset (async, active-high), i_push, i_pop, i_wdata,    |
// |           o_rdata (head entry), o_full, o_empty, o_count.             |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module synth_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int             c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full_count = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full_count) || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/synth_voice_allocator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : synth_voice_allocator                                       |
// | Polyphonic voice allocator. Note on/off commands arrive over a small  |
// | Avalon-MM slave, queue in a FIFO and are applied to the voice table   |
// | by an IDLE -> LOOKUP -> COMMIT sequencer.                             |
// | Ports   : clk, reset (async, active-high)                             |
// |           avs_s0_write/_writedata : command push                      |
// |           avs_s0_read/_readdata   : registered status word            |
// |           o_voice_valid/_note/_vel: voice table                       |
// |           o_wave_sel, o_busy                                          |
// | Option  : `define VOICE_STEAL_EN to evict the oldest voice when no    |
// |           slot is free (default: the command is dropped).             |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module synth_voice_allocator
    import synth_pkg::*;
#(
    parameter int NVOICES    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      avs_s0_write,
    input  logic [31:0]               avs_s0_writedata,
    input  logic                      avs_s0_read,
    output logic [31:0]               avs_s0_readdata,
    output logic [NVOICES-1:0]        o_voice_valid,
    output logic [NOTE_W*NVOICES-1:0] o_voice_note,
    output logic [VEL_W*NVOICES-1:0]  o_voice_vel,
    output logic [1:0]                o_wave_sel,
    output logic                      o_busy
);

    localparam int c_idx_w = $clog2(NVOICES);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_pop;
    logic [c_cmd_w-1:0]   w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic                 w_unused;

    logic [c_cmd_w-1:0]   r_cmd;
    logic                 w_cmd_on;
    logic [NOTE_W-1:0]    w_cmd_note;
    logic [VEL_W-1:0]     w_cmd_vel;

    logic [NVOICES-1:0]   r_valid;
    logic [NOTE_W-1:0]    r_note [NVOICES];
    logic [VEL_W-1:0]     r_vel  [NVOICES];
    logic [c_idx_w-1:0]   r_age  [NVOICES];

    logic                 w_match_hit, r_match_hit;
    logic [c_idx_w-1:0]   w_match_idx, r_match_idx;
    logic                 w_free_hit,  r_free_hit;
    logic [c_idx_w-1:0]   w_free_idx,  r_free_idx;
    logic                 w_oldest_hit;
    logic [c_idx_w-1:0]   w_oldest_idx, r_oldest_idx;
    logic [c_idx_w-1:0]   w_oldest_age;

    logic                 w_commit;
    logic                 w_can_alloc;
    logic                 w_new_voice;
    logic                 w_cmd_drop;
    logic                 w_fifo_drop;
    logic [c_idx_w-1:0]   w_target;
    logic [15:0]          w_valid_ext;

    wave_t                r_wave;
    logic                 r_drop;
    logic [31:0]          r_readdata;

    // Upper half of the bus word carries nothing.
    assign w_unused = ^avs_s0_writedata[31:16];

    synth_cmd_fifo #(
        .WIDTH (c_cmd_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (avs_s0_write),
        .i_pop   (w_pop),
        .i_wdata (avs_s0_writedata[c_cmd_w-1:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: w_next_state = ST_COMMIT;
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_cmd <= '0;
        else if (w_pop) r_cmd <= w_fifo_rdata;
    end

    assign w_cmd_on   = r_cmd[c_cmd_on_bit];
    assign w_cmd_note = r_cmd[c_cmd_note_lsb +: NOTE_W];
    assign w_cmd_vel  = r_cmd[c_cmd_vel_lsb +: VEL_W];

    // ---------------- lookup ----------------
    always_comb begin
        w_match_hit  = 1'b0;
        w_match_idx  = '0;
        w_free_hit   = 1'b0;
        w_free_idx   = '0;
        w_oldest_hit = 1'b0;
        w_oldest_idx = '0;
        w_oldest_age = '0;
        // Descending scan so the lowest free index wins.
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = c_idx_w'(i);
            end
        end
        // Strict '>' keeps the lowest index on equal ages.
        for (int i = 0; i < NVOICES; i++) begin
            if (r_valid[i] && (r_note[i] == w_cmd_note)) begin
                w_match_hit = 1'b1;
                w_match_idx = c_idx_w'(i);
            end
            if (r_valid[i] && (!w_oldest_hit || (r_age[i] > w_oldest_age))) begin
                w_oldest_hit = 1'b1;
                w_oldest_idx = c_idx_w'(i);
                w_oldest_age = r_age[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_hit  <= 1'b0;
            r_match_idx  <= '0;
            r_free_hit   <= 1'b0;
            r_free_idx   <= '0;
            r_oldest_idx <= '0;
        end else if (r_state == ST_LOOKUP) begin
            r_match_hit  <= w_match_hit;
            r_match_idx  <= w_match_idx;
            r_free_hit   <= w_free_hit;
            r_free_idx   <= w_free_idx;
            r_oldest_idx <= w_oldest_idx;
        end
    end

    // ---------------- commit ----------------
    assign w_commit = (r_state == ST_COMMIT);
    assign w_target = r_free_hit ? r_free_idx : r_oldest_idx;

`ifdef VOICE_STEAL_EN
    assign w_can_alloc = 1'b1;
`else
    assign w_can_alloc = r_free_hit;
`endif

    assign w_new_voice = w_commit && w_cmd_on && (w_cmd_note != WAVE_CMD_NOTE)
                         && !r_match_hit && w_can_alloc;
    assign w_cmd_drop  = w_commit && w_cmd_on && (w_cmd_note != WAVE_CMD_NOTE)
                         && !r_match_hit && !w_can_alloc;

    // Active notes are never 0, so a wave command can never match a voice
    // and falls through every branch below untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else if (w_commit) begin
            if (!w_cmd_on && (w_cmd_note == STOP_ALL_NOTE)) begin
                r_valid <= '0;
                for (int i = 0; i < NVOICES; i++) r_age[i] <= '0;
            end else if (w_cmd_on && r_match_hit) begin
                r_vel[r_match_idx] <= w_cmd_vel;
            end else if (w_new_voice) begin
                for (int i = 0; i < NVOICES; i++) begin
                    if (r_valid[i] && (c_idx_w'(i) != w_target))
                        r_age[i] <= r_age[i] + c_idx_w'(1);
                end
                r_valid[w_target] <= 1'b1;
                r_note[w_target]  <= w_cmd_note;
                r_vel[w_target]   <= w_cmd_vel;
                r_age[w_target]   <= '0;
            end else if (!w_cmd_on && r_match_hit) begin
                r_valid[r_match_idx] <= 1'b0;
                r_age[r_match_idx]   <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wave <= WAVE_SINE;
        else if (w_commit && w_cmd_on && (w_cmd_note == WAVE_CMD_NOTE))
            r_wave <= wave_t'(r_wave + 2'd1);
    end

    // ---------------- status ----------------
    assign w_fifo_drop = avs_s0_write && w_fifo_full && !w_pop;

    // A new drop outranks the clear-on-read so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           r_drop <= 1'b0;
        else if (w_fifo_drop || w_cmd_drop)  r_drop <= 1'b1;
        else if (avs_s0_read)                r_drop <= 1'b0;
    end

    always_comb begin
        w_valid_ext = '0;
        for (int i = 0; i < NVOICES; i++) w_valid_ext[i] = r_valid[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_readdata <= '0;
        else if (avs_s0_read)
            r_readdata <= {12'd0, o_busy, r_drop, r_wave, w_valid_ext};
    end

    // ---------------- outputs ----------------
    generate
        for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice_out
            assign o_voice_note[NOTE_W*gi +: NOTE_W] = r_note[gi];
            assign o_voice_vel[VEL_W*gi +: VEL_W]    = r_vel[gi];
        end
    endgenerate

    assign o_voice_valid   = r_valid;
    assign o_wave_sel      = r_wave;
    assign o_busy          = (w_fifo_count != '0) || (r_state != ST_IDLE);
    assign avs_s0_readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_synth_voice_allocator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_synth_voice_allocator                                    |
// | Directed bench for synth_voice_allocator (NVOICES=16, FIFO_DEPTH=4).  |
// | Each status read pushes its hand-computed expectation; a monitor pops |
// | and compares when the read data is presented.                         |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_synth_voice_allocator;

    localparam int NV = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                avs_s0_write;
    logic [31:0]         avs_s0_writedata;
    logic                avs_s0_read;
    logic [31:0]         avs_s0_readdata;
    logic [NV-1:0]       o_voice_valid;
    logic [7*NV-1:0]     o_voice_note;
    logic [8*NV-1:0]     o_voice_vel;
    logic [1:0]          o_wave_sel;
    logic                o_busy;

    typedef struct {
        logic [31:0] status;
        logic [15:0] valid;
        logic [1:0]  wave;
        int          vidx;   // voice whose note/vel is checked, -1 = none
        logic [6:0]  note;
        logic [7:0]  vel;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;
    int   m_rd_num = 0;
    logic rd_seen;

    synth_voice_allocator #(.NVOICES(NV), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
        .o_voice_valid    (o_voice_valid),
        .o_voice_note     (o_voice_note),
        .o_voice_vel      (o_voice_vel),
        .o_wave_sel       (o_wave_sel),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s read#%0d actual=0x%0h required=0x%0h", name, m_rd_num, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= avs_s0_read;
    end

    always @(negedge clk) begin
        if (rd_seen && !reset) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read read#%0d actual=0x%0h required=none", m_rd_num, avs_s0_readdata);
            end else begin
                m_e = q.pop_front();
                chk("status", avs_s0_readdata, m_e.status);
                chk("valid", {16'd0, o_voice_valid}, {16'd0, m_e.valid});
                chk("wave", {30'd0, o_wave_sel}, {30'd0, m_e.wave});
                if (m_e.vidx >= 0) begin
                    chk("note", {25'd0, o_voice_note[7*m_e.vidx +: 7]}, {25'd0, m_e.note});
                    chk("vel", {24'd0, o_voice_vel[8*m_e.vidx +: 8]}, {24'd0, m_e.vel});
                end
            end
            m_rd_num++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic exp_t mk(input logic [31:0] st, input logic [15:0] v, input logic [1:0] wv,
                                input int vi, input logic [6:0] n, input logic [7:0] vl);
        exp_t e;
        e.status = st; e.valid = v; e.wave = wv; e.vidx = vi; e.note = n; e.vel = vl;
        return e;
    endfunction

    // One clock: drive, optionally register an expectation, advance past the edge.
    task automatic step(input bit w, input logic [31:0] wd, input bit r, input exp_t e);
        avs_s0_write     = w;
        avs_s0_writedata = wd;
        avs_s0_read      = r;
        if (r) q.push_back(e);
        @(posedge clk);
        #1;
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, mk(0, 0, 0, -1, 0, 0));
    endtask

    // Write and wait until the command has been committed.
    task automatic cmd(input logic [31:0] wd);
        step(1'b1, wd, 1'b0, mk(0, 0, 0, -1, 0, 0));
        idle(3);
    endtask

    task automatic rd(input exp_t e);
        step(1'b0, 32'd0, 1'b1, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset            = 1'b1;
        avs_s0_write     = 1'b0;
        avs_s0_writedata = '0;
        avs_s0_read      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state: everything zero
        rd(mk(32'h0, 16'h0, 2'd0, 0, 7'd0, 8'd0));

        // A4 start; reads every cycle expose busy = exactly 3 cycles and the
        // table update on the third edge. Upper word bits are junk.
        step(1'b1, 32'hABCD_C500, 1'b1, mk(32'h00000, 16'h0, 2'd0, -1, 0, 0));
        rd(mk(32'h80000, 16'h0, 2'd0, -1, 0, 0));
        rd(mk(32'h80000, 16'h0, 2'd0, -1, 0, 0));
        rd(mk(32'h80000, 16'h1, 2'd0, 0, 7'd69, 8'h00));
        rd(mk(32'h00001, 16'h1, 2'd0, 0, 7'd69, 8'h00));

        // Waveform rotation, voices untouched
        cmd(32'h8000); rd(mk(32'h10001, 16'h1, 2'd1, 0, 7'd69, 8'h00));
        cmd(32'h8000); rd(mk(32'h20001, 16'h1, 2'd2, 0, 7'd69, 8'h00));
        cmd(32'h8000); rd(mk(32'h30001, 16'h1, 2'd3, 0, 7'd69, 8'h00));
        cmd(32'h8000); rd(mk(32'h00001, 16'h1, 2'd0, 0, 7'd69, 8'h00));

        // Stop all
        cmd(32'h7F00); rd(mk(32'h0, 16'h0, 2'd0, -1, 0, 0));

        // Notes 26, 28, 29 then stop 28; 69 refills voice 1
        cmd(32'h9A10); cmd(32'h9C20); cmd(32'h9D30); cmd(32'h1C00);
        rd(mk(32'h5, 16'h5, 2'd0, 2, 7'd29, 8'h30));
        cmd(32'hC540);
        rd(mk(32'h7, 16'h7, 2'd0, 1, 7'd69, 8'h40));
        // Retrigger of an active note changes velocity only
        cmd(32'h9D77);
        rd(mk(32'h7, 16'h7, 2'd0, 2, 7'd29, 8'h77));
        // Off for an inactive note and for note 0: no effect
        cmd(32'h0500); cmd(32'h0000);
        rd(mk(32'h7, 16'h7, 2'd0, 0, 7'd26, 8'h10));

        // NVOICES+1 distinct starts: notes 40..56, velocity = index
        cmd(32'h7F00);
        for (int k = 0; k < NV + 1; k++)
            cmd(32'h8000 | (32'(40 + k) << 8) | 32'(k));
`ifdef VOICE_STEAL_EN
        rd(mk(32'h0FFFF, 16'hFFFF, 2'd0, 0, 7'd56, 8'd16));
`else
        rd(mk(32'h4FFFF, 16'hFFFF, 2'd0, 0, 7'd40, 8'd0));
`endif
        rd(mk(32'h0FFFF, 16'hFFFF, 2'd0, 15, 7'd55, 8'd15));

        // Burst of six starts (notes 60..65) written while an inactive
        // note-off is being popped, so the FSM stays busy: only four more
        // entries fit and the sixth is dropped.
        cmd(32'h7F00);
        step(1'b1, 32'h0500, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hBC01, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hBD02, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hBE03, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hBF04, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hC005, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hC106, 1'b0, mk(0, 0, 0, -1, 0, 0));
        idle(20);
        rd(mk(32'h4001F, 16'h001F, 2'd0, 4, 7'd64, 8'd5));
        rd(mk(32'h0001F, 16'h001F, 2'd0, 0, 7'd60, 8'd1));

        // Stop-all with five voices active
        cmd(32'h7F00);
        rd(mk(32'h0, 16'h0, 2'd0, -1, 0, 0));

        // Non-zero state, then reset while a start is in LOOKUP and
        // another start is still queued
        cmd(32'h8000);
        cmd(32'h9011);
        rd(mk(32'h10001, 16'h1, 2'd1, 0, 7'd16, 8'h11));
        step(1'b1, 32'hA022, 1'b0, mk(0, 0, 0, -1, 0, 0));
        step(1'b1, 32'hA133, 1'b0, mk(0, 0, 0, -1, 0, 0));
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        rd(mk(32'h0, 16'h0, 2'd0, 0, 7'd0, 8'd0));
        idle(10);
        rd(mk(32'h0, 16'h0, 2'd0, 0, 7'd0, 8'd0));
        idle(3);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
